// File: rtl/la_cellbist_pkg.sv
// Shared stdlib BIST definitions: FSM state encoding and default MISR polynomials.
package la_cellbist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } bist_state_e;

  // Default MISR feedback taps (x^SIGW term implicit) for the common widths.
  localparam logic [15:0] BIST_POLY16 = 16'h1021;
  localparam logic [7:0]  BIST_POLY8  = 8'h07;

endpackage

// File: rtl/la_misr.sv
// Multiple-input signature register compacting one cell output bit per update.
module la_misr
  import la_cellbist_pkg::*;
#(
  parameter int              SIGW = 16,
  parameter logic [SIGW-1:0] POLY = SIGW'(BIST_POLY16),
  parameter string           PROP = "DEFAULT"
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            clear,
  input  logic            en,
  input  logic            din,
  output logic [SIGW-1:0] sig
);

  logic [SIGW-1:0] sig_q;
  logic [SIGW-1:0] sig_step;

  // Shift left, fold the outgoing MSB back through the polynomial, inject din at bit 0.
  assign sig_step = {sig_q[SIGW-2:0], 1'b0}
                  ^ (sig_q[SIGW-1] ? POLY : '0)
                  ^ {{(SIGW-1){1'b0}}, din};

  assign sig = sig_q;

  if (PROP == "NOENABLE") begin : g_mux
    // Flows that avoid enable flops get an explicit hold mux in front of a free-running register.
    logic [SIGW-1:0] sig_d;

    // Select clear / update / hold ahead of the register.
    always_comb begin
      sig_d = sig_q;
      if (clear) begin
        sig_d = '0;
      end else if (en) begin
        sig_d = sig_step;
      end
    end

    // Signature register, synchronous active-low reset.
    always_ff @(posedge clk) begin
      if (!nreset) begin
        sig_q <= '0;
      end else begin
        sig_q <= sig_d;
      end
    end
  end else begin : g_en
    // Signature register with clear taking priority over an update.
    always_ff @(posedge clk) begin
      if (!nreset) begin
        sig_q <= '0;
      end else if (clear) begin
        sig_q <= '0;
      end else if (en) begin
        sig_q <= sig_step;
      end
    end
  end

endmodule

// File: rtl/la_cellbist.sv
// Exhaustive-pattern BIST around a small combinational cell: vector generator, settle timer,
// MISR compaction of the cell output and a final compare against a golden signature.
module la_cellbist
  import la_cellbist_pkg::*;
#(
  parameter int              N      = 5,
  parameter int              SETTLE = 2,
  parameter int              SIGW   = 16,
  parameter logic [SIGW-1:0] POLY   = SIGW'(BIST_POLY16),
  parameter string           PROP   = "DEFAULT"
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            start,
  input  logic [SIGW-1:0] golden,
  output logic [N-1:0]    dut_in,
  input  logic            dut_z,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [SIGW-1:0] signature
);

  localparam int             SCW         = $clog2(SETTLE + 1);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE - 1);
  localparam logic [N-1:0]   VEC_LAST    = '1;

  bist_state_e     state_q, state_d;
  logic [N-1:0]    vec_q, vec_d;
  logic [SCW-1:0]  settle_q, settle_d;
  logic            pass_q, pass_d;
  logic            misr_clear;
  logic            misr_en;
  logic [SIGW-1:0] misr_next;

  // The value the MISR will take on an update edge; used so pass reflects the final signature.
  assign misr_next = {signature[SIGW-2:0], 1'b0}
                   ^ (signature[SIGW-1] ? POLY : '0)
                   ^ {{(SIGW-1){1'b0}}, dut_z};

  // Next-state and datapath control: start a run, hold each vector SETTLE cycles, finish on all-ones.
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    settle_d   = settle_q;
    pass_d     = pass_q;
    misr_clear = 1'b0;
    misr_en    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_RUN;
          vec_d      = '0;
          settle_d   = '0;
          pass_d     = 1'b0;
          misr_clear = 1'b1;
        end
      end
      ST_RUN: begin
        if (settle_q == SETTLE_LAST) begin
          misr_en = 1'b1;
          if (vec_q == VEC_LAST) begin
            state_d = ST_DONE;
            pass_d  = (misr_next == golden);
          end else begin
            vec_d    = vec_q + N'(1);
            settle_d = '0;
          end
        end else begin
          settle_d = settle_q + SCW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, vector, settle and pass registers; reset abandons any run in progress.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q  <= ST_IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      pass_q   <= pass_d;
    end
  end

  la_misr #(
    .SIGW (SIGW),
    .POLY (POLY),
    .PROP (PROP)
  ) u_misr (
    .clk    (clk),
    .nreset (nreset),
    .clear  (misr_clear),
    .en     (misr_en),
    .din    (dut_z),
    .sig    (signature)
  );

  // Stimulus comes straight from the vector flops so the cell sees glitch-free inputs.
  assign dut_in = vec_q;
  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);
  assign pass   = pass_q;

endmodule

// File: tb/tb_la_cellbist.sv
// Self-checking bench for la_cellbist: three configurations (N=1/2/5) driven with directed runs,
// plus a per-cycle behavioural model of the N=5 instance.
module tb_la_cellbist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nreset;
  logic        start1, start2, start5;
  logic [15:0] golden1, golden2, golden5;
  logic        and_mode2;
  logic        mode5;

  logic [0:0]  in1;
  logic [1:0]  in2;
  logic [4:0]  in5;
  logic        z1, z2, z5;
  logic        busy1, done1, pass1;
  logic        busy2, done2, pass2;
  logic        busy5, done5, pass5;
  logic [15:0] sig1, sig2, sig5;

  int tests_run    = 0;
  int tests_failed = 0;
  bit chk_en       = 1'b0;

  // Cells under test: buffer, AND/OR pair, and (in0|in1|in2)&in3&in4 or 5-input parity.
  assign z1 = in1[0];
  assign z2 = and_mode2 ? (in2[0] & in2[1]) : (in2[0] | in2[1]);
  assign z5 = mode5 ? (^in5) : ((in5[0] | in5[1] | in5[2]) & in5[3] & in5[4]);

  la_cellbist #(.N(1), .SETTLE(1), .SIGW(16), .POLY(16'h1021), .PROP("DEFAULT")) u_n1 (
    .clk(clk), .nreset(nreset), .start(start1), .golden(golden1), .dut_in(in1),
    .dut_z(z1), .busy(busy1), .done(done1), .pass(pass1), .signature(sig1));

  la_cellbist #(.N(2), .SETTLE(2), .SIGW(16), .POLY(16'h1021), .PROP("DEFAULT")) u_n2 (
    .clk(clk), .nreset(nreset), .start(start2), .golden(golden2), .dut_in(in2),
    .dut_z(z2), .busy(busy2), .done(done2), .pass(pass2), .signature(sig2));

  la_cellbist #(.N(5), .SETTLE(2), .SIGW(16), .POLY(16'h1021), .PROP("DEFAULT")) u_n5 (
    .clk(clk), .nreset(nreset), .start(start5), .golden(golden5), .dut_in(in5),
    .dut_z(z5), .busy(busy5), .done(done5), .pass(pass5), .signature(sig5));

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic z);
    logic [15:0] r;
    r = {s[14:0], 1'b0};
    if (s[15]) r = r ^ 16'h1021;
    r[0] = r[0] ^ z;
    return r;
  endfunction

  function automatic logic cell5(input int v, input logic m);
    int b0, b1, b2, b3, b4;
    b0 = v % 2; b1 = (v / 2) % 2; b2 = (v / 4) % 2; b3 = (v / 8) % 2; b4 = (v / 16) % 2;
    if (m) return ((b0 + b1 + b2 + b3 + b4) % 2) == 1;
    return ((b0 + b1 + b2) > 0) && (b3 == 1) && (b4 == 1);
  endfunction

  // Signature after folding the cell response for every vector 0..31 in order.
  function automatic logic [15:0] model_run5(input logic m);
    logic [15:0] s;
    s = '0;
    for (int v = 0; v < 32; v++) s = misr_step(s, cell5(v, m));
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Hold the current inputs for a number of clocks; returns 1ns after the last rising edge.
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // N=5 model: elapsed-time view of the run (vector index, cycles in vector, folded signature).
  bit          m_run, m_done, m_pass;
  int          m_held;
  int          m_vec;
  logic [15:0] m_sig;

  initial begin
    m_run = 0; m_done = 0; m_pass = 0; m_held = 0; m_vec = 0; m_sig = '0;
    forever begin
      @(posedge clk);
      if (!nreset) begin
        m_run = 0; m_done = 0; m_pass = 0; m_held = 0; m_vec = 0; m_sig = '0;
      end else if (!m_run && start5) begin
        m_run = 1; m_done = 0; m_pass = 0; m_held = 0; m_vec = 0; m_sig = '0;
      end else if (m_run) begin
        m_held++;
        if (m_held == 2) begin
          m_sig  = misr_step(m_sig, cell5(m_vec, mode5));
          m_held = 0;
          if (m_vec == 31) begin
            m_run  = 0;
            m_done = 1;
            m_pass = (m_sig == golden5);
          end else begin
            m_vec++;
          end
        end
      end
      #1;
      if (chk_en)
        checkOutput("n5_cycle", {8'h0, in5, busy5, done5, pass5, sig5},
                    {8'h0, 5'(m_vec), m_run, m_done, m_pass, m_sig});
    end
  end

  task automatic run2(input bit am, input logic [15:0] g, input logic [15:0] exp_sig,
                      input bit exp_pass, input string nm);
    int cycles;
    and_mode2 = am;
    golden2   = g;
    start2    = 1'b1;
    applyStimulus(1);
    start2 = 1'b0;
    cycles = 0;
    while (!done2 && cycles < 100) begin
      applyStimulus(1);
      cycles++;
    end
    checkOutput({nm, "_latency"}, cycles, 8);
    checkOutput({nm, "_sig"}, sig2, exp_sig);
    checkOutput({nm, "_pass"}, pass2, exp_pass);
    checkOutput({nm, "_vec"}, in2, 2'd3);
  endtask

  // Run the N=5 instance; start stays high for hold cycles into the run.
  task automatic run5(input int hold, input logic [15:0] g, input logic [15:0] exp_sig,
                      input bit exp_pass, input string nm);
    int n, busy_cnt;
    golden5 = g;
    start5  = 1'b1;
    applyStimulus(1);
    checkOutput({nm, "_start_done"}, done5, 0);
    checkOutput({nm, "_start_busy"}, busy5, 1);
    checkOutput({nm, "_start_seed"}, sig5, 16'h0000);
    n = 0;
    busy_cnt = 0;
    while (!done5 && n < 200) begin
      if (busy5) busy_cnt++;
      if (n == hold) start5 = 1'b0;
      applyStimulus(1);
      n++;
    end
    start5 = 1'b0;
    checkOutput({nm, "_busy_cycles"}, busy_cnt, 64);
    checkOutput({nm, "_sig"}, sig5, exp_sig);
    checkOutput({nm, "_pass"}, pass5, exp_pass);
    checkOutput({nm, "_vec"}, in5, 5'd31);
  endtask

  initial begin
    nreset = 1'b0;
    start1 = 1'b0; start2 = 1'b0; start5 = 1'b0;
    golden1 = 16'h0001; golden2 = '0; golden5 = '0;
    and_mode2 = 1'b1; mode5 = 1'b0;
    applyStimulus(2);
    chk_en = 1'b1;

    checkOutput("rst_busy", {busy1, busy2, busy5}, 0);
    checkOutput("rst_done", {done1, done2, done5}, 0);
    checkOutput("rst_pass", {pass1, pass2, pass5}, 0);
    checkOutput("rst_sig", {sig1, sig2}, 0);
    checkOutput("rst_vec", {in1, in2, in5}, 0);
    nreset = 1'b1;
    applyStimulus(1);

    start1 = 1'b1;
    applyStimulus(1);
    start1 = 1'b0;
    checkOutput("n1_busy_start", busy1, 1);
    checkOutput("n1_done_start", done1, 0);
    applyStimulus(1);
    checkOutput("n1_done_c1", done1, 0);
    checkOutput("n1_vec_c1", in1, 1);
    applyStimulus(1);
    checkOutput("n1_done_c2", done1, 1);
    checkOutput("n1_busy_c2", busy1, 0);
    checkOutput("n1_sig", sig1, 16'h0001);
    checkOutput("n1_pass", pass1, 1);

    run2(1'b1, 16'h0001, 16'h0001, 1'b1, "n2_and");
    run2(1'b0, 16'h0007, 16'h0007, 1'b1, "n2_or_good");
    run2(1'b0, 16'h0001, 16'h0007, 1'b0, "n2_or_bad");

    mode5 = 1'b0;
    run5(0, model_run5(1'b0), 16'h007F, 1'b1, "n5_clean");

    start5 = 1'b1;
    applyStimulus(1);
    start5 = 1'b0;
    applyStimulus(9);
    nreset = 1'b0;
    applyStimulus(1);
    checkOutput("mid_rst_vec", in5, 0);
    checkOutput("mid_rst_flags", {busy5, done5, pass5}, 0);
    checkOutput("mid_rst_sig", sig5, 16'h0000);
    nreset = 1'b1;
    applyStimulus(1);
    run5(0, 16'h007F, 16'h007F, 1'b1, "n5_after_rst");

    run5(40, 16'h007F, 16'h007F, 1'b1, "n5_start_held");
    run5(0, 16'h007F, 16'h007F, 1'b1, "n5_rerun");

    mode5 = 1'b1;
    run5(0, model_run5(1'b1), model_run5(1'b1), 1'b1, "n5_parity");
    run5(0, ~model_run5(1'b1), model_run5(1'b1), 1'b0, "n5_parity_bad");

    applyStimulus(3);
    checkOutput("n5_done_hold", {done5, busy5}, 2'b10);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/la_cellbist.md
Name: la_cellbist

Overview:
- Exhaustive-pattern built-in self-test engine for small combinational stdlib cells, such as the or-and family with up to 8 inputs.
- Sits directly around the cell under test:
  - drives every input combination onto the cell inputs (upstream stage);
  - compacts the cell output into a MISR signature (downstream stage);
  - compares the signature against a golden value.
- Used in silicon cell-qualification rings and in the stdlib regression bench.

Parameters:
- N, 5, number of cell inputs driven (1..8); vector space is 2^N.
- SETTLE, 2, cycles each vector is held before its output is sampled (>=1).
- SIGW, 16, MISR/signature width (>=4).
- POLY, 16'h1021, MISR feedback polynomial (SIGW bits, x^SIGW term implicit).
- PROP, "DEFAULT", implementation property string, passed through to the sub-module.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- nreset, input, 1, reset; synchronous, active-low.
- start, input, 1, begin a test run; sampled only in IDLE or DONE.
- golden, input, SIGW, expected signature; sampled at end of run.
- dut_in, output, N, stimulus vector to the cell inputs (bit0 = first input, e.g. a0).
- dut_z, input, 1, cell output.
- busy, output, 1, run in progress.
- done, output, 1, run complete; level, held.
- pass, output, 1, signature==golden; valid while done=1, else 0.
- signature, output, SIGW, current MISR contents.

Behaviour:
- Reset (nreset=0 at a rising edge):
  - state=IDLE;
  - dut_in=0, busy=0, done=0, pass=0, signature=0, settle counter=0;
  - applies from any state, including mid-run; the run is abandoned with no partial result.
- States:
  - IDLE: wait for start.
  - RUN: step through all vectors.
  - DONE: hold the result.
- IDLE/DONE, start=1:
  - next state RUN;
  - dut_in=0, signature=0 (seed), settle count=0;
  - busy=1, done=0, pass=0.
- RUN timing:
  - Each vector is held on dut_in for exactly SETTLE cycles.
  - On the edge ending the SETTLE-th cycle:
    - signature <= (signature<<1) ^ (signature[SIGW-1] ? POLY : 0) ^ {{SIGW-1{0}}, dut_z};
    - if dut_in != 2^N-1: dut_in increments by 1 and the settle count clears;
    - else: state=DONE.
- Latency: start edge to done=1 is SETTLE*2^N cycles.
  - Exactly 2^N MISR updates occur.
  - dut_in never wraps during a run.
- RUN -> DONE edge:
  - busy=0, done=1;
  - pass = (final signature == golden), where golden is sampled on this same edge;
  - dut_in holds 2^N-1.
- DONE: all outputs hold until reset or start. start re-runs the test; no clear is needed.
- start during RUN: ignored.
- golden changes outside the final edge: no effect.
- Arithmetic:
  - settle counter width is clog2(SETTLE+1);
  - vector counter is N bits, and the terminal compare is against all-ones;
  - no overflow path exists.
- dut_in is driven from flops only (glitch-free stimulus to the cell).
- dut_z is sampled directly. The cell is combinational, so SETTLE covers its delay; no synchronizer.

Decomposition:
- Shared stdlib BIST package holds:
  - state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - default POLY constants per SIGW (16'h1021, 8'h07).
- One natural sub-module: la_misr.
  - Parameters: SIGW, POLY.
  - Ports: clk, nreset, clear, en, din, sig.
  - Implements the shift/feedback equation with synchronous active-low reset.
- la_cellbist keeps the FSM, the vector counter and the settle counter.

Test Plan:
- N=1, SETTLE=1, dut_z=dut_in[0] (buffer), golden=16'h0001, start pulse:
  - done rises 2 cycles after the start edge;
  - signature=16'h0001, pass=1.
- N=2, SETTLE=2, dut_z = AND of the inputs: signature=16'h0001 after 8 cycles.
- N=2, SETTLE=2, dut_z = OR of the inputs: signature=16'h0007.
  - With golden=16'h0007: pass=1.
  - With golden=16'h0001: pass=0.
- N=5, SETTLE=2, dut_z=(in0|in1|in2)&in3&in4:
  - busy is high for exactly 64 cycles;
  - dut_in steps 0..31, each value held 2 cycles;
  - signature matches the bench model; pass=1 with the model value as golden.
- Reset mid-run (nreset=0 at cycle 10 of the N=5 run):
  - next edge shows dut_in=0, busy=0, done=0, pass=0, signature=0;
  - a subsequent start gives the same result as a clean run.
- Back-to-back runs:
  - start held high during RUN: no restart, no change to the result.
  - start pulsed in DONE: a new run begins with done=0 on that edge and ends with the identical signature.
